regfile_param: RTL
==================

Name: regfile_param

Overview:
- Parametrised successor to the team's 32x32 register file: configurable data width and address width, two combinational read ports plus a debug read port, and one synchronous write port.
- Adds synchronous reset, optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a multi-cycle clear sweep (FSM) with a busy flag and a dropped-write indication.
- Sits in the datapath as the core's architectural register file; the debug port feeds the VIO probe bus.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW registers.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable, sampled on rising clk.
- rd  input  AW  write address.
- indata  input  DW  write data.
- rs1  input  AW  read address, port 1.
- rs2  input  AW  read address, port 2.
- rv1  output  DW  read data, port 1 (combinational).
- rv2  output  DW  read data, port 2 (combinational).
- dbg_addr  input  AW  debug read address.
- dbg_data  output  DW  debug read data (combinational, never bypassed).
- clr_req  input  1  request clear sweep; sampled in IDLE only.
- busy  output  1  high while clear sweep in progress.
- wr_drop  output  1  registered one-cycle pulse: a write was discarded.

Behaviour:
- Reset (rst=1 at a rising clk):
  - all DEPTH registers := 0; FSM := IDLE; sweep counter := 0; busy := 0; wr_drop := 0.
  - Reset overrides any concurrent we or clr_req.
  - Reset mid-sweep aborts the sweep and returns to IDLE with all registers zero.
- Reads: rvN = mem[rsN], combinational, zero latency. dbg_data = mem[dbg_addr].
- ZERO_REG=1: any read of address 0 returns 0, including under bypass. A write to address 0 is silently ignored; it is not a dropped write and wr_drop stays 0.
- Write, IDLE state: if we=1 (and rd!=0 when ZERO_REG=1), mem[rd] := indata at the rising edge. The new value is visible on rv1/rv2/dbg_data in the following cycle.
- Bypass:
  - BYPASS=1: in the same cycle, if we=1, FSM=IDLE, rd==rsN and the write is not to a zero register, then rvN = indata.
  - BYPASS=0: rvN shows the old value until the next cycle.
  - dbg_data is never bypassed.
- FSM states IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1: sweep counter := 0 and busy := 1 from the next cycle.
  - A write presented in the same cycle as clr_req (while IDLE) is performed normally; the sweep later zeroes it.
  - CLEAR: each cycle mem[cnt] := 0 and cnt := cnt+1. After clearing address DEPTH-1, FSM := IDLE and busy := 0. The sweep takes exactly DEPTH cycles with busy high.
  - CLEAR: clr_req is ignored.
  - CLEAR: any we=1 is discarded, and wr_drop=1 in the next cycle, including writes to register 0. Bypass is disabled.
  - CLEAR: reads return the current array contents; swept entries read 0, unswept entries keep their old values.
- wr_drop: registered, high for exactly one cycle per dropped write; back-to-back drops hold it high.
- Counter width is AW bits. Termination is on cnt == DEPTH-1, not on overflow.
- Simultaneous rs1==rs2==rd: both ports are bypassed identically.

Test Plan:
- Reset then read: rst=1 for 1 cycle; rs1=3, rs2=31, dbg_addr=7 -> rv1=rv2=dbg_data=0, busy=0, wr_drop=0.
- Write/read with bypass: we=1, rd=5, indata=0xDEADBEEF, rs1=5, rs2=6 -> same cycle rv1=0xDEADBEEF (BYPASS=1), rv2=0. Next cycle with we=0, dbg_addr=5 -> dbg_data=0xDEADBEEF. With BYPASS=0, rv1 shows 0 in the write cycle.
- Zero register: we=1, rd=0, indata=0x12345678, rs1=0 -> rv1=0 in the write cycle and the next; wr_drop stays 0.
- Clear sweep: fill regs 1..31 with value=index; pulse clr_req -> busy high for exactly 32 cycles. Mid-sweep after 10 cycles: reg 9 reads 0, reg 20 reads 20. After busy falls, all 32 registers read 0.
- Dropped write: during CLEAR drive we=1, rd=31, indata=0xAAAA5555 -> wr_drop=1 for one cycle; after the sweep reg 31 = 0. The same write in IDLE the cycle after busy falls lands, and reg 31 = 0xAAAA5555 next cycle.
- Reset mid-sweep: clr_req, then rst at sweep cycle 5 -> next cycle busy=0, FSM IDLE, all registers 0. A new clr_req restarts a full 32-cycle sweep.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised architectural register file: two bypassable read ports, one debug
// read port, one write port, and a DEPTH-cycle clear sweep that drops writes.
//   state    | meaning
//   ST_IDLE  | normal operation, writes land, bypass active
//   ST_CLEAR | sweeping mem[cnt] := 0, writes dropped, busy high
module regfile_param #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] rd,
  input  logic [DW-1:0] indata,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic [DW-1:0] rv1,
  output logic [DW-1:0] rv2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          clr_req,
  output logic          busy,
  output logic          wr_drop
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_drop_q, wr_drop_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic wr_zero;
  logic wr_en;

  // Writes to a hardwired zero register are ignored, not dropped.
  assign wr_zero = (ZERO_REG != 0) && (rd == '0);
  assign wr_en   = we && (state_q == ST_IDLE) && !wr_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        wr_drop_d = we;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[rd] <= indata;
    end
  end

  always_comb begin
    rv1 = mem_q[rs1];
    if ((BYPASS != 0) && wr_en && (rd == rs1)) rv1 = indata;
    if ((ZERO_REG != 0) && (rs1 == '0)) rv1 = '0;
  end

  always_comb begin
    rv2 = mem_q[rs2];
    if ((BYPASS != 0) && wr_en && (rd == rs2)) rv2 = indata;
    if ((ZERO_REG != 0) && (rs2 == '0)) rv2 = '0;
  end

  // Debug port is a plain array view, never forwarded.
  always_comb begin
    dbg_data = mem_q[dbg_addr];
    if ((ZERO_REG != 0) && (dbg_addr == '0)) dbg_data = '0;
  end

  assign busy    = (state_q == ST_CLEAR);
  assign wr_drop = wr_drop_q;

endmodule
